// File: rtl/key_scan_pkg.sv
// Shared constants for the key-scan peripheral: register offsets, EVENT word
// layout, STATUS/CTRL bit positions and the queued event payload.
package key_scan_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_EVENT  = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int unsigned EV_KEY_LSB   = 0;
  localparam int unsigned EV_KEY_MSB   = 1;
  localparam int unsigned EV_PRESS_BIT = 8;
  localparam int unsigned EV_TS_LSB    = 15;
  localparam int unsigned EV_TS_MSB    = 30;
  localparam int unsigned EV_VALID_BIT = 31;

  localparam int unsigned ST_COUNT_LSB = 0;
  localparam int unsigned ST_COUNT_MSB = 4;
  localparam int unsigned ST_EMPTY_BIT = 5;
  localparam int unsigned ST_FULL_BIT  = 6;
  localparam int unsigned ST_OVF_BIT   = 7;
  localparam int unsigned ST_KEY_LSB   = 8;
  localparam int unsigned ST_KEY_MSB   = 11;

  localparam int unsigned CTRL_IRQ_EN_BIT  = 0;
  localparam int unsigned CTRL_FLUSH_BIT   = 1;
  localparam int unsigned CTRL_OVF_CLR_BIT = 2;

  typedef struct packed {
    logic       press;
    logic [1:0] key;
  } key_ev_t;

  // Build the CPU-visible EVENT word for a valid FIFO head entry.
  function automatic logic [31:0] ev_word(input key_ev_t ev, input logic [15:0] ts);
    logic [31:0] w;
    w = '0;
    w[EV_VALID_BIT]           = 1'b1;
    w[EV_TS_MSB:EV_TS_LSB]    = ts;
    w[EV_PRESS_BIT]           = ev.press;
    w[EV_KEY_MSB:EV_KEY_LSB]  = ev.key;
    return w;
  endfunction

endpackage

// File: rtl/key_scan_debounce.sv
// One button: 2-FF synchroniser on the active-low pin, stability counter and
// single-cycle press/release qualifiers coincident with the key_state update.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw_n,
  output logic key_state,
  output logic press_c,
  output logic release_c
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          key_q, key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_c;

  assign level_c   = ~sync_q[1];
  assign key_state = key_q;

  // Count consecutive cycles of disagreement; accept the new level on the last one.
  always_comb begin
    sync_d    = {sync_q[0], raw_n};
    key_d     = key_q;
    cnt_d     = '0;
    press_c   = 1'b0;
    release_c = 1'b0;
    if (level_c != key_q) begin
      if (cnt_q == CNT_LAST) begin
        key_d     = ~key_q;
        press_c   = ~key_q;
        release_c = key_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 2'b11;
      key_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      key_q  <= key_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/perip_key_scan.sv
// Four-button debounce front-end with a CPU-readable press/release event FIFO.
// Define KEY_SCAN_TIMESTAMP_EN to stamp a millisecond counter into EVENT[30:15].
module perip_key_scan
  import key_scan_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 25000000,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  buttons_raw,
  input  logic        cs,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic [3:0]  key_state,
  output logic        irq
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [3:0] press_c, release_c;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk       (clk),
      .resetn    (resetn),
      .raw_n     (buttons_raw[i]),
      .key_state (key_state[i]),
      .press_c   (press_c[i]),
      .release_c (release_c[i])
    );
  end

  // Pending stage: lowest-index event drains into the FIFO each cycle.
  logic [3:0] pend_q, pend_d, pend_press_q, pend_press_d, drain_c;
  logic [1:0] drain_idx_c;
  key_ev_t    push_ev_c;
  logic       push_req_c;

  always_comb begin
    drain_c = pend_q & (~pend_q + 4'd1);
    casez (pend_q)
      4'b???1: drain_idx_c = 2'd0;
      4'b??10: drain_idx_c = 2'd1;
      4'b?100: drain_idx_c = 2'd2;
      4'b1000: drain_idx_c = 2'd3;
      default: drain_idx_c = 2'd0;
    endcase
    pend_d          = (pend_q & ~drain_c) | press_c | release_c;
    pend_press_d    = (pend_press_q & ~(press_c | release_c)) | press_c;
    push_req_c      = |pend_q;
    push_ev_c.press = pend_press_q[drain_idx_c];
    push_ev_c.key   = drain_idx_c;
  end

  logic [1:0] sel_c;
  logic       rd_hit_c, wr_ctrl_c, pop_c, flush_c, ovf_clr_c;
  logic       empty_c, full_c, do_push_c, drop_c;

  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic [31:0]      d_out_q, d_out_d, status_c;
  logic [15:0]      head_ts_c;
  key_ev_t          mem_q [FIFO_DEPTH];

  assign sel_c     = addr[3:2];
  assign rd_hit_c  = cs & rd;
  assign wr_ctrl_c = cs & wr & (sel_c == REG_CTRL);
  assign flush_c   = wr_ctrl_c & d_in[CTRL_FLUSH_BIT];
  assign ovf_clr_c = wr_ctrl_c & d_in[CTRL_OVF_CLR_BIT];
  assign empty_c   = (cnt_q == '0);
  assign full_c    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign pop_c     = rd_hit_c & (sel_c == REG_EVENT) & ~empty_c;
  // A pop frees the slot before the push lands; a flush discards both.
  assign do_push_c = push_req_c & (~full_c | pop_c) & ~flush_c;
  assign drop_c    = push_req_c & full_c & ~pop_c & ~flush_c;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    if (pop_c)     rptr_d = rptr_q + AW'(1);
    if (do_push_c) wptr_d = wptr_q + AW'(1);
    case ({do_push_c, pop_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (flush_c) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
    if (ovf_clr_c) ovf_d = 1'b0;
    if (drop_c)    ovf_d = 1'b1;
    if (wr_ctrl_c) irq_en_d = d_in[CTRL_IRQ_EN_BIT];
    irq_d = irq_en_d & (cnt_d != '0);
  end

  // Read data mux, sampled from pre-edge state.
  always_comb begin
    status_c = '0;
    status_c[ST_COUNT_MSB:ST_COUNT_LSB] = 5'(cnt_q);
    status_c[ST_EMPTY_BIT]              = empty_c;
    status_c[ST_FULL_BIT]               = full_c;
    status_c[ST_OVF_BIT]                = ovf_q;
    status_c[ST_KEY_MSB:ST_KEY_LSB]     = key_state;
    d_out_d = d_out_q;
    if (rd_hit_c) begin
      case (sel_c)
        REG_STATUS: d_out_d = status_c;
        REG_EVENT:  d_out_d = empty_c ? 32'd0 : ev_word(mem_q[rptr_q], head_ts_c);
        REG_CTRL: begin
          d_out_d = '0;
          d_out_d[CTRL_IRQ_EN_BIT] = irq_en_q;
        end
        default:    d_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_q       <= '0;
      pend_press_q <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      irq_en_q     <= 1'b0;
      irq_q        <= 1'b0;
      d_out_q      <= '0;
    end else begin
      pend_q       <= pend_d;
      pend_press_q <= pend_press_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
      d_out_q      <= d_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wptr_q] <= push_ev_c;
  end

`ifdef KEY_SCAN_TIMESTAMP_EN
  localparam int unsigned MS_DIV = (CLK_FREQ >= 2000) ? (CLK_FREQ / 1000) : 2;

  logic [31:0] pre_q, pre_d;
  logic [15:0] ms_q, ms_d;
  logic [15:0] ts_mem_q [FIFO_DEPTH];

  // Free-running millisecond tick, wraps naturally at 16 bits.
  always_comb begin
    pre_d = pre_q + 32'd1;
    ms_d  = ms_q;
    if (pre_q == 32'(MS_DIV - 1)) begin
      pre_d = '0;
      ms_d  = ms_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else begin
      pre_q <= pre_d;
      ms_q  <= ms_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) ts_mem_q[wptr_q] <= ms_q;
  end

  assign head_ts_c = ts_mem_q[rptr_q];
`else
  assign head_ts_c = '0;
`endif

  logic unused_ok;
  assign unused_ok = ^{addr[31:4], addr[1:0], d_in[31:3], 1'(CLK_FREQ)};

  assign d_out = d_out_q;
  assign irq   = irq_q;

endmodule
